// File: rtl/sipo_shift_receiver_pkg.sv
// Shared types and sizes for the SIPO shift receiver.
// SIPO_PARITY_EN selects a 9-bit frame (8 data bits plus an odd-parity bit).
package sipo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME_LEN = 9;
`else
  localparam int unsigned FRAME_LEN = 8;
`endif

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_e;

  // Completed frame handed from the shifter to the output latch
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity_err;
  } frame_t;

endpackage

// File: rtl/sipo_shift_receiver_if.sv
// Serial-in / consumer-side signal bundle for the SIPO shift receiver.
interface sipo_shift_receiver_if;
  import sipo_pkg::*;

  logic              ser;
  logic              shift_en;
  logic              frame_rst;
  logic              data_ready;
  logic [DATA_W-1:0] q;
  logic              qh_prime;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              overrun;
  logic              parity_err;

  modport master (
    output ser, shift_en, frame_rst, data_ready,
    input  q, qh_prime, data_out, data_valid, overrun, parity_err
  );

  modport slave (
    input  ser, shift_en, frame_rst, data_ready,
    output q, qh_prime, data_out, data_valid, overrun, parity_err
  );

endinterface

// File: rtl/sipo_out_latch.sv
// Holds the last completed frame and applies the valid/ready and overrun rules.
module sipo_out_latch
  import sipo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_done,
  input  frame_t            frame,
  input  logic              data_ready,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun,
  output logic              parity_err
);

  // A new frame replaces the held one only if the held one is gone or leaving now
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (frame_done) begin
        if (data_valid && !data_ready) begin
          overrun <= 1'b1;
        end else begin
          data_out   <= frame.data;
          parity_err <= frame.parity_err;
          data_valid <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_shift_receiver.sv
// Serial-in parallel-out receiver: LSB-first shift register, bit counter and frame FSM.
// Build with SIPO_PARITY_EN defined for a trailing odd-parity bit per frame.
module sipo_shift_receiver
  import sipo_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  sipo_shift_receiver_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] shifted_c;
  logic              frame_done_c;
  frame_t            frame_c;

  assign shifted_c = {bus.ser, q_q[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_DATA;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  // Parity strobes leave q and the counter alone so q still holds the frame's data bits
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_d          = q_q;
    frame_done_c = 1'b0;
    frame_c      = '0;
    if (bus.frame_rst) begin
      state_d = S_DATA;
      cnt_d   = '0;
      q_d     = '0;
    end else if (bus.shift_en) begin
      case (state_q)
        S_DATA: begin
          q_d   = shifted_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SIPO_PARITY_EN
            state_d = S_PAR;
`else
            frame_done_c = 1'b1;
            frame_c.data = shifted_c;
`endif
          end
        end
        S_PAR: begin
`ifdef SIPO_PARITY_EN
          frame_done_c       = 1'b1;
          frame_c.data       = q_q;
          frame_c.parity_err = ~(^{bus.ser, q_q});
`endif
          state_d = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  assign bus.q        = q_q;
  assign bus.qh_prime = q_q[0];

  sipo_out_latch u_out_latch (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_done  (frame_done_c),
    .frame       (frame_c),
    .data_ready  (bus.data_ready),
    .overrun_clr (bus.frame_rst),
    .data_out    (bus.data_out),
    .data_valid  (bus.data_valid),
    .overrun     (bus.overrun),
    .parity_err  (bus.parity_err)
  );

endmodule

// File: doc/sipo_shift_receiver.md
SIPO_SHIFT_RECEIVER -- requirements
Module: sipo_shift_receiver

Interface
- REQ-001 SHALL: clk  input  1  system clock; all state changes occur on the rising edge.
- REQ-002 SHALL: rst_n  input  1  reset; one clock, reset synchronous and active-low.
- REQ-003 SHALL: ser  input  1  serial data, LSB first; pairs with the 8-bit PISO serial output qh.
- REQ-004 SHALL: shift_en  input  1  bit strobe; ser is sampled on each rising edge where shift_en=1.
- REQ-005 SHALL: frame_rst  input  1  synchronous resync; aborts the partial frame.
- REQ-006 SHALL: data_ready  input  1  consumer accepts data_out when data_valid=1 and data_ready=1.
- REQ-007 SHALL: q  output  8  live shift register contents.
- REQ-008 SHALL: qh_prime  output  1  cascade output, equal to q[0].
- REQ-009 SHALL: data_out  output  8  latched, completed frame.
- REQ-010 SHALL: data_valid  output  1  data_out holds an unconsumed frame.
- REQ-011 SHALL: overrun  output  1  sticky flag: a completed frame was dropped.
- REQ-012 SHALL: parity_err  output  1  parity result of the frame in data_out.

Function
- REQ-013 SHALL: on each rising edge with shift_en=1 and frame_rst=0:
  - q <= {ser, q[7:1]};
  - bit_cnt increments.
- REQ-014 SHALL: use a 3-bit bit_cnt, 0..7, that wraps to 0 after the 8th data bit.
- REQ-015 SHALL: use an FSM with states S_DATA and S_PAR.
  - S_PAR exists only under the macro (REQ-027).
  - S_DATA -> S_PAR on the 8th data bit; S_PAR -> S_DATA on the next strobe.
- REQ-016 SHALL: a frame completes on the rising edge that samples its last bit.
  - On that edge, data_out, data_valid and parity_err update.
  - They are visible in the next cycle, with zero extra latency.
- REQ-017 SHALL: latch data_out from the post-shift value {ser, q[7:1]} when the last bit is a data bit.
  - When the last bit is the parity bit, latch from q.
- REQ-018 SHALL: data_valid clears on an edge with data_valid=1 and data_ready=1, unless a frame completes on that same edge.
- REQ-019 SHALL: handle a frame completing while data_valid=1 and data_ready=0 as follows:
  - drop the new frame;
  - keep data_out and parity_err unchanged;
  - set overrun to 1.
- REQ-020 SHALL: when a frame completes on the same edge as a valid&ready accept:
  - latch the new frame;
  - keep data_valid at 1;
  - leave overrun unchanged.
- REQ-021 SHALL: frame_rst=1 has priority over shift_en and acts as follows:
  - q <= 0, bit_cnt <= 0, state <= S_DATA, overrun <= 0;
  - data_out, data_valid and parity_err are not affected.
- REQ-022 SHALL: with shift_en=0, q, bit_cnt and state hold their values indefinitely, with no timeout.
- REQ-023 SHALL: overrun clears only on reset or frame_rst.

Reset
- REQ-024 SHALL: rst_n=0 sampled at a rising edge sets the following to 0, and returns the FSM to S_DATA:
  - q, bit_cnt, data_out, data_valid, overrun, parity_err.
- REQ-025 SHALL: reset has priority over frame_rst, shift_en and data_ready.
- REQ-026 SHALL: reset mid-frame discards all partial bits; the next strobe after release is data bit 0.

Configuration
- REQ-027 SHALL: SIPO_PARITY_EN defined selects a 9-bit frame: 8 data bits LSB first, then one odd-parity bit.
  - parity_err <= 1 when the XOR of the 9 bits is 0.
- REQ-028 SHALL: SIPO_PARITY_EN undefined selects an 8-bit frame.
  - S_PAR is absent; parity_err is tied to 0.
  - The port list is identical in both builds.

Structure
- REQ-029 SHALL: shared package sipo_pkg holds the following:
  - DATA_W=8 and CNT_W=3;
  - the state enum (S_DATA, S_PAR);
  - FRAME_LEN, which is 9 or 8 depending on SIPO_PARITY_EN.
- REQ-030 SHALL: use one sub-module, sipo_out_latch.
  - It holds data_out, data_valid, parity_err and overrun.
  - It implements the valid/ready and overrun rules (REQ-018..020).
  - It takes a frame_done pulse, the frame data and the parity result.
- REQ-031 SHALL: keep the top level as the shift register, bit counter and FSM, in 120-400 lines total.

Verification
- REQ-032 SHALL: 8-bit build; drive ser=1,0,1,0,0,1,0,1 on 8 consecutive strobes with data_ready=0.
  - data_out=0xA5 and data_valid=1 one cycle after the 8th strobe; q=0xA5.
- REQ-033 SHALL: with data_valid=1 and data_ready=0, shift a second frame 0x3C.
  - overrun=1, data_out stays 0xA5.
  - Then data_ready=1 for 1 cycle gives data_valid=0, overrun still 1.
- REQ-034 SHALL: assert data_ready=1 on the same edge as the 8th bit of 0x0F while 0xA5 is pending.
  - data_out=0x0F, data_valid=1, overrun=0.
- REQ-035 SHALL: shift 3 bits, then frame_rst=1 for 1 cycle, then a full 0x81.
  - q=0 after frame_rst; data_out=0x81; no spurious frame.
- REQ-036 SHALL: parity build; send 0xA5 followed by parity bit 1, giving parity_err=0.
  - Send 0xA5 followed by parity bit 0, giving parity_err=1.
  - data_valid rises only after the 9th strobe.
- REQ-037 SHALL: rst_n=0 for 1 cycle after 5 bits, then a full frame 0xFF.
  - All outputs are 0 after reset; data_out=0xFF after 8 more strobes.
